// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arbiter_pkg;

    localparam int unsigned DATA_WIDTH           = 32;
    localparam int unsigned DMEM_TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } dmem_arb_state_t;

    // A timeout of 0 still needs a 1-bit counter.
    function automatic int unsigned tmo_cnt_width(input int unsigned cycles);
        return (cycles == 0) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side bus signals of the data-memory arbiter.
interface dmem_arbiter_if;
    import dmem_arbiter_pkg::*;

    logic                  m0_req;
    logic [DATA_WIDTH-1:0] m0_addr;
    logic                  m0_we;
    logic [DATA_WIDTH-1:0] m0_wdata;
    logic                  m0_ack;
    logic [DATA_WIDTH-1:0] m0_rdata;
    logic                  m0_err;

    logic                  m1_req;
    logic [DATA_WIDTH-1:0] m1_addr;
    logic                  m1_we;
    logic [DATA_WIDTH-1:0] m1_wdata;
    logic                  m1_ack;
    logic [DATA_WIDTH-1:0] m1_rdata;
    logic                  m1_err;

    logic                  dmem_req;
    logic [DATA_WIDTH-1:0] dmem_addr;
    logic                  dmem_we;
    logic [DATA_WIDTH-1:0] dmem_wdata;
    logic [DATA_WIDTH-1:0] dmem_rdata;
    logic                  dmem_ack;

    // Arbiter side.
    modport slave (
        input  m0_req, m0_addr, m0_we, m0_wdata,
        output m0_ack, m0_rdata, m0_err,
        input  m1_req, m1_addr, m1_we, m1_wdata,
        output m1_ack, m1_rdata, m1_err,
        output dmem_req, dmem_addr, dmem_we, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    // Requesters and memory side.
    modport master (
        output m0_req, m0_addr, m0_we, m0_wdata,
        input  m0_ack, m0_rdata, m0_err,
        output m1_req, m1_addr, m1_we, m1_wdata,
        input  m1_ack, m1_rdata, m1_err,
        input  dmem_req, dmem_addr, dmem_we, dmem_wdata,
        output dmem_rdata, dmem_ack
    );

endinterface

// File: rtl/dmem_arb_rr.sv
// Combinational 2-way round-robin select; on contention the port not granted last wins.
module dmem_arb_rr (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = (req == 2'b11) ? ~last_gnt : req[1];
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the load/store unit (port 0) and debug/DMA (port 1),
// one transaction outstanding, with an optional ack timeout.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DMEM_TIMEOUT_DEFAULT
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    dmem_arbiter_if.slave  bus
);

    localparam int unsigned CntW = tmo_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] ToLast =
        (TIMEOUT_CYCLES == 0) ? '0 : CntW'(TIMEOUT_CYCLES - 1);

    dmem_arb_state_t       state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  last_gnt_q, last_gnt_d;
    logic                  owner_q, owner_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [1:0]            ack_q, ack_d;
    logic [1:0]            err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

    logic                  gnt_valid, gnt_idx;
    logic                  done, done_err;
    logic [DATA_WIDTH-1:0] done_rdata;

    dmem_arb_rr u_rr (
        .req       ({bus.m1_req, bus.m0_req}),
        .last_gnt  (last_gnt_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_gnt_d = last_gnt_q;
        owner_d    = owner_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ack_d      = '0;
        err_d      = '0;
        rdata0_d   = '0;
        rdata1_d   = '0;
        done       = 1'b0;
        done_err   = 1'b0;
        done_rdata = '0;

        unique case (state_q)
            StIdle: begin
                if (gnt_valid) begin
                    owner_d    = gnt_idx;
                    last_gnt_d = gnt_idx;
                    addr_d     = gnt_idx ? bus.m1_addr  : bus.m0_addr;
                    we_d       = gnt_idx ? bus.m1_we    : bus.m0_we;
                    wdata_d    = gnt_idx ? bus.m1_wdata : bus.m0_wdata;
                    req_d      = 1'b1;
                    cnt_d      = '0;
                    state_d    = StBusy;
                end
            end
            StBusy: begin
                cnt_d = cnt_q + CntW'(1);
                // Ack wins over a timeout landing in the same cycle.
                if (bus.dmem_ack) begin
                    done       = 1'b1;
                    done_rdata = bus.dmem_rdata;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == ToLast)) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                end
                if (done) begin
                    state_d        = StResp;
                    req_d          = 1'b0;
                    ack_d[owner_q] = 1'b1;
                    err_d[owner_q] = done_err;
                    if (owner_q) rdata1_d = done_rdata;
                    else         rdata0_d = done_rdata;
                end
            end
            StResp: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            last_gnt_q <= 1'b1;
            owner_q    <= 1'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ack_q      <= '0;
            err_q      <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_gnt_q <= last_gnt_d;
            owner_q    <= owner_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    assign bus.dmem_req   = req_q;
    assign bus.dmem_addr  = addr_q;
    assign bus.dmem_we    = we_q;
    assign bus.dmem_wdata = wdata_q;
    assign bus.m0_ack     = ack_q[0];
    assign bus.m0_err     = err_q[0];
    assign bus.m0_rdata   = rdata0_q;
    assign bus.m1_ack     = ack_q[1];
    assign bus.m1_err     = err_q[1];
    assign bus.m1_rdata   = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized checks of dmem_arbiter against a transaction-level reference model.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dmem_arbiter_if bus();

    dmem_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Memory responder: acks after cur_delay extra cycles of dmem_req.
    bit          resp_en;
    int          resp_delay;      // -1 picks a random delay 0..20 per transaction
    bit          resp_fixed;
    logic [31:0] resp_fixed_data;
    bit          force_ack;
    int          busy_cnt;
    int          cur_delay;
    bit          ack_given;
    logic [31:0] ack_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mem_step();
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = $urandom;
        if (bus.dmem_req === 1'b1) begin
            busy_cnt++;
            if (busy_cnt == 1) begin
                cur_delay = (resp_delay < 0) ? int'($urandom_range(20, 0)) : resp_delay;
                ack_given = 1'b0;
            end
            if (resp_en && busy_cnt == cur_delay + 1) begin
                bus.dmem_ack = 1'b1;
                if (resp_fixed) bus.dmem_rdata = resp_fixed_data;
                ack_given = 1'b1;
                ack_data  = bus.dmem_rdata;
            end
        end else begin
            busy_cnt = 0;
        end
        if (force_ack) begin
            bus.dmem_ack = 1'b1;
            force_ack    = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mem_step();
    endtask

    task automatic set_req(input bit p, input bit r, input logic [31:0] a, input bit w,
                           input logic [31:0] d);
        if (p) begin
            bus.m1_req = r; bus.m1_addr = a; bus.m1_we = w; bus.m1_wdata = d;
        end else begin
            bus.m0_req = r; bus.m0_addr = a; bus.m0_we = w; bus.m0_wdata = d;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_req(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        set_req(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".dmem_req"}, 32'(bus.dmem_req), 32'h0);
        check({tag, ".dmem_addr"}, bus.dmem_addr, 32'h0);
        check({tag, ".dmem_we"}, 32'(bus.dmem_we), 32'h0);
        check({tag, ".dmem_wdata"}, bus.dmem_wdata, 32'h0);
        check({tag, ".m0_ack"}, 32'(bus.m0_ack), 32'h0);
        check({tag, ".m0_rdata"}, bus.m0_rdata, 32'h0);
        check({tag, ".m0_err"}, 32'(bus.m0_err), 32'h0);
        check({tag, ".m1_ack"}, 32'(bus.m1_ack), 32'h0);
        check({tag, ".m1_rdata"}, bus.m1_rdata, 32'h0);
        check({tag, ".m1_err"}, 32'(bus.m1_err), 32'h0);
    endtask

    // One isolated transaction on port p; checks bus fields, ack routing, data and pulse width.
    task automatic run_txn(input string tag, input bit p, input logic [31:0] a, input bit w,
                           input logic [31:0] d, input int delay, input bit en,
                           input logic [31:0] exp_rdata, input bit exp_err, input int exp_cyc);
        int req_cycles = 0;
        bit done = 1'b0;
        logic own_ack, oth_ack;
        resp_en    = en;
        resp_delay = delay;
        set_req(p, 1'b1, a, w, d);
        for (int i = 0; i < 60 && !done; i++) begin
            tick();
            own_ack = p ? bus.m1_ack : bus.m0_ack;
            oth_ack = p ? bus.m0_ack : bus.m1_ack;
            check({tag, ".other_ack"}, 32'(oth_ack), 32'h0);
            if (bus.dmem_req === 1'b1) begin
                req_cycles++;
                check({tag, ".addr"}, bus.dmem_addr, a);
                check({tag, ".we"}, 32'(bus.dmem_we), 32'(w));
                check({tag, ".wdata"}, bus.dmem_wdata, d);
            end
            if (own_ack === 1'b1) begin
                check({tag, ".rdata"}, p ? bus.m1_rdata : bus.m0_rdata, exp_rdata);
                check({tag, ".err"}, 32'(p ? bus.m1_err : bus.m0_err), 32'(exp_err));
                set_req(p, 1'b0, 32'h0, 1'b0, 32'h0);
                done = 1'b1;
            end
        end
        check({tag, ".completed"}, 32'(done), 32'h1);
        check({tag, ".req_cycles"}, req_cycles, exp_cyc);
        tick();
        check({tag, ".ack_pulse"}, 32'(p ? bus.m1_ack : bus.m0_ack), 32'h0);
        check({tag, ".rdata_idle"}, p ? bus.m1_rdata : bus.m0_rdata, 32'h0);
        set_req(p, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        bit          prev_req;
        int          grants, acks, low_cnt, owner, last_served, issued, completed, req_cycles;
        bit          active;
        bit          pend [2];
        logic [31:0] paddr [2];
        logic [31:0] pwdata [2];
        bit          pwe [2];
        bit          p;

        rst_n = 1'b0;
        bus.dmem_ack = 1'b0;
        bus.dmem_rdata = 32'h0;
        resp_en = 1'b1; resp_delay = 0; resp_fixed = 1'b1; resp_fixed_data = 32'h0;
        force_ack = 1'b0; busy_cnt = 0; cur_delay = 0; ack_given = 1'b0; ack_data = 32'h0;

        // Reset state
        do_reset();
        check_all_zero("reset");

        // Single load on port 0, ack two cycles after the request appears
        resp_fixed_data = 32'hDEAD_BEEF;
        run_txn("load", 1'b0, 32'h100, 1'b0, 32'h0, 2, 1'b1, 32'hDEAD_BEEF, 1'b0, 3);

        // Single store on port 1; read data is still returned
        resp_fixed_data = 32'hCAFE_F00D;
        run_txn("store", 1'b1, 32'h20, 1'b1, 32'h1234_5678, 1, 1'b1, 32'hCAFE_F00D, 1'b0, 2);

        // Timeout: memory never answers
        run_txn("timeout", 1'b0, 32'h300, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b1, 16);
        force_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("late_ack.m0_ack", 32'(bus.m0_ack), 32'h0);
            check("late_ack.m1_ack", 32'(bus.m1_ack), 32'h0);
            check("late_ack.dmem_req", 32'(bus.dmem_req), 32'h0);
        end

        // Contention with immediate acks: m0, m1, m0, m1 with two idle cycles between issues
        do_reset();
        resp_en = 1'b1; resp_delay = 0;
        set_req(1'b0, 1'b1, 32'hA0, 1'b0, 32'h0);
        set_req(1'b1, 1'b1, 32'hB0, 1'b1, 32'h11);
        prev_req = 1'b0; grants = 0; acks = 0; low_cnt = 0;
        for (int i = 0; i < 40 && acks < 4; i++) begin
            tick();
            if (bus.dmem_req === 1'b1 && !prev_req) begin
                check("contend.addr", bus.dmem_addr, (grants % 2 == 1) ? 32'hB0 : 32'hA0);
                if (grants > 0) check("contend.gap", low_cnt, 2);
                grants++;
                low_cnt = 0;
            end
            if (bus.dmem_req !== 1'b1) low_cnt++;
            prev_req = (bus.dmem_req === 1'b1);
            check("contend.dual_ack", 32'(bus.m0_ack & bus.m1_ack), 32'h0);
            if (bus.m0_ack === 1'b1 || bus.m1_ack === 1'b1) begin
                check("contend.owner", 32'(bus.m1_ack), 32'(acks % 2));
                acks++;
            end
        end
        check("contend.acks", acks, 4);

        // Reset while a transaction is in flight
        do_reset();
        resp_en = 1'b0;
        set_req(1'b1, 1'b1, 32'h44, 1'b0, 32'h0);
        for (int i = 0; i < 5 && bus.dmem_req !== 1'b1; i++) tick();
        check("midrst.busy", 32'(bus.dmem_req), 32'h1);
        rst_n = 1'b0;
        set_req(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        rst_n = 1'b1;
        check_all_zero("midrst");
        force_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst.m0_ack", 32'(bus.m0_ack), 32'h0);
            check("midrst.m1_ack", 32'(bus.m1_ack), 32'h0);
        end
        resp_en = 1'b1; resp_delay = 1; resp_fixed_data = 32'h5A5A_0001;
        set_req(1'b0, 1'b1, 32'h55, 1'b0, 32'h0);
        set_req(1'b1, 1'b1, 32'h66, 1'b0, 32'h0);
        acks = 0; prev_req = 1'b0;
        for (int i = 0; i < 10 && acks == 0; i++) begin
            tick();
            if (bus.dmem_req === 1'b1 && !prev_req) check("midrst.first_addr", bus.dmem_addr, 32'h55);
            prev_req = (bus.dmem_req === 1'b1);
            if (bus.m0_ack === 1'b1 || bus.m1_ack === 1'b1) begin
                check("midrst.first_owner_m0", 32'(bus.m0_ack), 32'h1);
                check("midrst.first_rdata", bus.m0_rdata, 32'h5A5A_0001);
                acks++;
            end
        end
        check("midrst.got_ack", acks, 1);

        // Random soak against a transaction-level model
        do_reset();
        resp_fixed = 1'b0; resp_en = 1'b1; resp_delay = -1;
        pend[0] = 1'b0; pend[1] = 1'b0;
        last_served = 1; active = 1'b0; owner = 0; issued = 0; completed = 0;
        req_cycles = 0; prev_req = 1'b0;
        for (int cyc = 0; cyc < 5400; cyc++) begin
            tick();
            if (bus.dmem_req === 1'b1 && !prev_req) begin
                if (!pend[0] && !pend[1]) begin
                    check("soak.spurious_issue", 32'h1, 32'h0);
                end else begin
                    owner = (pend[0] && pend[1]) ? 1 - last_served : (pend[1] ? 1 : 0);
                    last_served = owner;
                    check("soak.overlap", 32'(active), 32'h0);
                    check("soak.addr", bus.dmem_addr, paddr[owner]);
                    check("soak.we", 32'(bus.dmem_we), 32'(pwe[owner]));
                    check("soak.wdata", bus.dmem_wdata, pwdata[owner]);
                    active = 1'b1;
                    issued++;
                    req_cycles = 0;
                end
            end
            if (bus.dmem_req === 1'b1) req_cycles++;
            prev_req = (bus.dmem_req === 1'b1);
            if (bus.m0_ack === 1'b1 || bus.m1_ack === 1'b1) begin
                p = bus.m1_ack;
                check("soak.dual_ack", 32'(bus.m0_ack & bus.m1_ack), 32'h0);
                check("soak.active", 32'(active), 32'h1);
                check("soak.owner", 32'(p), owner);
                check("soak.err", 32'(p ? bus.m1_err : bus.m0_err), 32'(!ack_given));
                check("soak.rdata", p ? bus.m1_rdata : bus.m0_rdata,
                      ack_given ? ack_data : 32'h0);
                if (!ack_given) check("soak.tmo_len", req_cycles, 16);
                active = 1'b0;
                completed++;
                pend[p] = 1'b0;
                set_req(p, 1'b0, 32'h0, 1'b0, 32'h0);
            end
            if (cyc < 5000) begin
                for (int q = 0; q < 2; q++) begin
                    if (!pend[q] && $urandom_range(2, 0) == 0) begin
                        pend[q]   = 1'b1;
                        paddr[q]  = $urandom;
                        pwe[q]    = 1'($urandom_range(1, 0));
                        pwdata[q] = $urandom;
                        set_req(1'(q), 1'b1, paddr[q], pwe[q], pwdata[q]);
                    end
                end
            end else if (!pend[0] && !pend[1] && !active) begin
                break;
            end
        end
        check("soak.issued_eq_completed", issued, completed);
        check("soak.drained", 32'(pend[0] | pend[1] | active), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
